// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-read-port register file.
package regfile_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } regfile_state_t;

  function automatic int addr_width(input int nregs);
    return $clog2(nregs);
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One registered read port: zero-register / write-bypass / storage select into the rs_out flop.
module regfile_read_port #(
  parameter int XLEN     = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            flush,
  input  logic            we,
  input  logic [AW-1:0]   rd,
  input  logic [XLEN-1:0] rd_in,
  input  logic [AW-1:0]   rs,
  input  logic [XLEN-1:0] stored,
  output logic [XLEN-1:0] rs_out
);

  logic [XLEN-1:0] next_out;

  always_comb begin
    next_out = stored;
    if (ZERO_REG != 0 && rs == '0) begin
      next_out = '0;
    end else if (we && rd == rs) begin
      next_out = rd_in;
    end
  end

  // read stage -> registered output
  always_ff @(posedge clock) begin
    if (!reset_n || flush) begin
      rs_out <= '0;
    end else begin
      rs_out <= next_out;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file with NREAD registered read ports, write bypass and a
// sequential clear sweep so the storage array itself needs no reset.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                               clock,
  input  logic                               reset_n,
  input  logic                               we,
  input  logic [addr_width(NREGS)-1:0]       rd,
  input  logic [XLEN-1:0]                    rd_in,
  input  logic [NREAD*addr_width(NREGS)-1:0] rs,
  output logic [NREAD*XLEN-1:0]              rs_out,
  input  logic                               clear,
  output logic                               busy
);

  localparam int AW = addr_width(NREGS);

  regfile_state_t  state, state_next;
  logic [AW-1:0]   idx;
  logic            sweeping;
  logic            sweep_last;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [XLEN-1:0] wr_data;
  logic [XLEN-1:0] mem [NREGS];

  assign sweeping   = (state == CLEAR);
  assign sweep_last = (idx == AW'(NREGS - 1));

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (clear) state_next = CLEAR;
      CLEAR:   if (sweep_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A clear pulse in IDLE drops any write presented in the same cycle.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = rd;
    wr_data = rd_in;
    if (sweeping) begin
      wr_en   = 1'b1;
      wr_addr = idx;
      wr_data = '0;
    end else if (we && !clear && !(ZERO_REG != 0 && rd == '0)) begin
      wr_en = 1'b1;
    end
  end

  // control stage
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= CLEAR;
      idx   <= '0;
      busy  <= 1'b1;
    end else begin
      state <= state_next;
      busy  <= (state_next == CLEAR);
      idx   <= sweeping ? idx + 1'b1 : '0;
    end
  end

  // storage stage
  always_ff @(posedge clock) begin
    if (reset_n && wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  for (genvar p = 0; p < NREAD; p++) begin : g_read
    logic [AW-1:0] addr;
    assign addr = rs[p*AW +: AW];

    regfile_read_port #(
      .XLEN    (XLEN),
      .AW      (AW),
      .ZERO_REG(ZERO_REG)
    ) u_port (
      .clock  (clock),
      .reset_n(reset_n),
      .flush  (sweeping),
      .we     (we),
      .rd     (rd),
      .rd_in  (rd_in),
      .rs     (addr),
      .stored (mem[addr]),
      .rs_out (rs_out[p*XLEN +: XLEN])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: three configurations driven from one clock and checked cycle by
// cycle against an array model of the register file and its sweep duration.
module tb_regfile_mp;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        rstn_a, we_a, clear_a, busy_a;
  logic [4:0]  rd_a;
  logic [31:0] din_a;
  logic [9:0]  rs_a;
  logic [63:0] out_a;

  logic        rstn_b, we_b, clear_b, busy_b;
  logic [4:0]  rd_b;
  logic [31:0] din_b;
  logic [9:0]  rs_b;
  logic [63:0] out_b;

  logic        rstn_c, we_c, clear_c, busy_c;
  logic [2:0]  rd_c;
  logic [15:0] din_c;
  logic [11:0] rs_c;
  logic [63:0] out_c;

  regfile_mp #(.XLEN(32), .NREGS(32), .NREAD(2), .ZERO_REG(1)) dut_a (
    .clock(clock), .reset_n(rstn_a), .we(we_a), .rd(rd_a), .rd_in(din_a),
    .rs(rs_a), .rs_out(out_a), .clear(clear_a), .busy(busy_a));

  regfile_mp #(.XLEN(32), .NREGS(32), .NREAD(2), .ZERO_REG(0)) dut_b (
    .clock(clock), .reset_n(rstn_b), .we(we_b), .rd(rd_b), .rd_in(din_b),
    .rs(rs_b), .rs_out(out_b), .clear(clear_b), .busy(busy_b));

  regfile_mp #(.XLEN(16), .NREGS(8), .NREAD(4), .ZERO_REG(1)) dut_c (
    .clock(clock), .reset_n(rstn_c), .we(we_c), .rd(rd_c), .rd_in(din_c),
    .rs(rs_c), .rs_out(out_c), .clear(clear_c), .busy(busy_c));

  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] mem [3][32];
  int          left [3];
  int          nr [3]         = '{32, 32, 8};
  int          np [3]         = '{2, 2, 4};
  int          zr [3]         = '{1, 0, 1};
  logic [31:0] dmask [3]      = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_FFFF};

  // Drive one clock cycle on instance sel (others idle), predict, step, compare.
  task automatic cycle(input string tag, input int sel, input bit rstn, input bit we,
                       input int rd, input logic [31:0] din, input int r0, input int r1,
                       input int r2, input int r3, input bit clr);
    int          ra [4];
    logic [31:0] exp_out [4];
    logic [31:0] act;
    logic        exp_busy, act_busy;
    ra[0] = r0; ra[1] = r1; ra[2] = r2; ra[3] = r3;
    rstn_a = 1'b1; we_a = 1'b0; clear_a = 1'b0;
    rstn_b = 1'b1; we_b = 1'b0; clear_b = 1'b0;
    rstn_c = 1'b1; we_c = 1'b0; clear_c = 1'b0;
    case (sel)
      0: begin
        rstn_a = rstn; we_a = we; rd_a = 5'(rd); din_a = din; clear_a = clr;
        rs_a = {5'(r1), 5'(r0)};
      end
      1: begin
        rstn_b = rstn; we_b = we; rd_b = 5'(rd); din_b = din; clear_b = clr;
        rs_b = {5'(r1), 5'(r0)};
      end
      default: begin
        rstn_c = rstn; we_c = we; rd_c = 3'(rd); din_c = din[15:0]; clear_c = clr;
        rs_c = {3'(r3), 3'(r2), 3'(r1), 3'(r0)};
      end
    endcase
    for (int p = 0; p < 4; p++) exp_out[p] = '0;
    for (int i = 0; i < 3; i++) begin
      bit r_n, w, c;
      r_n = (i == sel) ? rstn : 1'b1;
      w   = (i == sel) ? we : 1'b0;
      c   = (i == sel) ? clr : 1'b0;
      if (!r_n) begin
        left[i] = nr[i];
        for (int k = 0; k < 32; k++) mem[i][k] = '0;
      end else if (left[i] > 0) begin
        left[i]--;
      end else begin
        if (i == sel) begin
          for (int p = 0; p < np[i]; p++) begin
            if (zr[i] != 0 && ra[p] == 0)   exp_out[p] = '0;
            else if (w && rd == ra[p])      exp_out[p] = din & dmask[i];
            else                            exp_out[p] = mem[i][ra[p]];
          end
        end
        if (c) begin
          left[i] = nr[i];
          for (int k = 0; k < 32; k++) mem[i][k] = '0;
        end else if (w && !(zr[i] != 0 && rd == 0)) begin
          mem[i][rd] = din & dmask[i];
        end
      end
    end
    exp_busy = (left[sel] > 0);
    @(posedge clock); #1;
    act_busy = (sel == 0) ? busy_a : (sel == 1) ? busy_b : busy_c;
    n_chk++;
    if (act_busy !== exp_busy) begin
      n_fail++;
      $display("FAIL %s busy: got %b expected %b", tag, act_busy, exp_busy);
    end
    for (int p = 0; p < np[sel]; p++) begin
      case (sel)
        0:       act = out_a[p*32 +: 32];
        1:       act = out_b[p*32 +: 32];
        default: act = {16'h0000, out_c[p*16 +: 16]};
      endcase
      n_chk++;
      if (act !== exp_out[p]) begin
        n_fail++;
        $display("FAIL %s rs_out[%0d]: got %h expected %h", tag, p, act, exp_out[p]);
      end
    end
  endtask

  task automatic test_reset();
    rstn_a = 1'b0; rstn_b = 1'b0; rstn_c = 1'b0;
    we_a = 1'b0; we_b = 1'b0; we_c = 1'b0;
    clear_a = 1'b0; clear_b = 1'b0; clear_c = 1'b0;
    rd_a = '0; rd_b = '0; rd_c = '0;
    din_a = '0; din_b = '0; din_c = '0;
    rs_a = '0; rs_b = '0; rs_c = '0;
    @(posedge clock); #1;
    for (int i = 0; i < 3; i++) begin
      left[i] = nr[i];
      for (int k = 0; k < 32; k++) mem[i][k] = '0;
    end
    n_chk++;
    if ({busy_a, busy_b, busy_c} !== 3'b111) begin
      n_fail++;
      $display("FAIL reset_busy: got %b expected 111", {busy_a, busy_b, busy_c});
    end
    n_chk++;
    if (out_a !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_out_a: got %h expected 0", out_a);
    end
    n_chk++;
    if (out_b !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_out_b: got %h expected 0", out_b);
    end
    n_chk++;
    if (out_c !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_out_c: got %h expected 0", out_c);
    end
    for (int k = 0; k < 32; k++)
      cycle("reset_sweep", 0, 1'b1, 1'b1, $urandom_range(31), $urandom,
            $urandom_range(31), $urandom_range(31), 0, 0, 1'b0);
    for (int k = 0; k < 16; k++)
      cycle("post_sweep_read", 0, 1'b1, 1'b0, 0, 32'h0, 2*k, 2*k + 1, 0, 0, 1'b0);
  endtask

  task automatic test_write_read();
    cycle("wr_r5", 0, 1'b1, 1'b1, 5, 32'hDEADBEEF, 1, 2, 0, 0, 1'b0);
    cycle("rd_r5", 0, 1'b1, 1'b0, 0, 32'h0, 5, 5, 0, 0, 1'b0);
  endtask

  task automatic test_bypass();
    cycle("wr_r7", 0, 1'b1, 1'b1, 7, 32'hAAAA0000, 0, 0, 0, 0, 1'b0);
    cycle("bypass_r7", 0, 1'b1, 1'b1, 7, 32'h12345678, 3, 7, 0, 0, 1'b0);
    cycle("stored_r7", 0, 1'b1, 1'b0, 0, 32'h0, 7, 7, 0, 0, 1'b0);
  endtask

  task automatic test_zero_reg();
    cycle("zr_write", 0, 1'b1, 1'b1, 0, 32'hFFFFFFFF, 0, 5, 0, 0, 1'b0);
    cycle("zr_read", 0, 1'b1, 1'b0, 0, 32'h0, 0, 0, 0, 0, 1'b0);
    cycle("nz_bypass", 1, 1'b1, 1'b1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 1'b0);
    cycle("nz_stored", 1, 1'b1, 1'b0, 0, 32'h0, 0, 0, 0, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 150; k++) begin
      int a, s0, s1;
      a  = $urandom_range(31);
      s0 = ($urandom_range(3) == 0) ? a : $urandom_range(31);
      s1 = ($urandom_range(3) == 0) ? a : $urandom_range(31);
      cycle("rand_a", 0, 1'b1, 1'($urandom_range(1)), a, $urandom, s0, s1, 0, 0, 1'b0);
    end
    for (int k = 0; k < 60; k++) begin
      int a;
      a = $urandom_range(31);
      cycle("rand_b", 1, 1'b1, 1'($urandom_range(1)), a, $urandom,
            ($urandom_range(1) == 0) ? a : $urandom_range(31), $urandom_range(31), 0, 0, 1'b0);
    end
  endtask

  task automatic test_clear_pulse();
    for (int k = 1; k < 32; k++)
      cycle("fill", 0, 1'b1, 1'b1, k, 32'(k), $urandom_range(31), $urandom_range(31), 0, 0, 1'b0);
    cycle("clear_pulse", 0, 1'b1, 1'b1, 9, 32'h5555AAAA, 3, 4, 0, 0, 1'b1);
    for (int k = 0; k < 32; k++)
      cycle("clear_busy", 0, 1'b1, 1'b1, 3, $urandom, 3, 9, 0, 0, 1'b1);
    cycle("r3_after_clear", 0, 1'b1, 1'b0, 0, 32'h0, 3, 9, 0, 0, 1'b0);
    cycle("refill_r9", 0, 1'b1, 1'b1, 9, 32'h0BADF00D, 9, 1, 0, 0, 1'b0);
    cycle("clear2", 0, 1'b1, 1'b0, 0, 32'h0, 9, 9, 0, 0, 1'b1);
    for (int k = 0; k < 9; k++)
      cycle("sweep2", 0, 1'b1, 1'b0, 0, 32'h0, 9, 2, 0, 0, 1'b0);
    cycle("reset_mid_sweep", 0, 1'b0, 1'b1, 4, 32'h1, 4, 9, 0, 0, 1'b1);
    for (int k = 0; k < 32; k++)
      cycle("resweep", 0, 1'b1, 1'b1, 4, $urandom, 4, 9, 0, 0, 1'b0);
    cycle("after_resweep", 0, 1'b1, 1'b0, 0, 32'h0, 9, 4, 0, 0, 1'b0);
  endtask

  task automatic test_params();
    for (int k = 1; k < 8; k++)
      cycle("c_fill", 2, 1'b1, 1'b1, k, $urandom, 0, 0, 0, 0, 1'b0);
    for (int k = 0; k < 32; k++) begin
      int a;
      a = $urandom_range(7);
      cycle("c_read", 2, 1'b1, 1'($urandom_range(3) == 0), $urandom_range(7), $urandom,
            a, (k % 2 == 1) ? a : $urandom_range(7), $urandom_range(7), a, 1'b0);
    end
    cycle("c_clear", 2, 1'b1, 1'b0, 0, 32'h0, 1, 2, 3, 4, 1'b1);
    for (int k = 0; k < 8; k++)
      cycle("c_sweep", 2, 1'b1, 1'b1, 5, $urandom, 5, 6, 7, 1, 1'b0);
    cycle("c_zero_lo", 2, 1'b1, 1'b0, 0, 32'h0, 0, 1, 2, 3, 1'b0);
    cycle("c_zero_hi", 2, 1'b1, 1'b0, 0, 32'h0, 4, 5, 6, 7, 1'b0);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_zero_reg();
    test_random();
    test_clear_pulse();
    test_params();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port register file for the core's decode/register-read stage. It generalises the 32×32, two-read-port file to configurable width, depth and read-port count. New behaviour:
- hardwired-zero register 0
- write-to-read bypass
- sequential clear sweep, so storage needs no per-bit reset and maps to distributed RAM

Reads are registered with one-cycle latency.

## Interface
Parameters:
- XLEN, 32, data width in bits
- NREGS, 32, number of registers; power of two, ≥ 2
- NREAD, 2, number of read ports, ≥ 1
- ZERO_REG, 1, when 1 register 0 reads as zero and ignores writes

Ports:
- clock  input  1  single clock; all state changes on its rising edge
- reset_n  input  1  synchronous, active-low reset
- we  input  1  write enable
- rd  input  log2(NREGS)  write address
- rd_in  input  XLEN  write data
- rs  input  NREAD×log2(NREGS)  read addresses, one per port
- rs_out  output  NREAD×XLEN  registered read data, one per port
- clear  input  1  single-cycle pulse; starts a clear sweep
- busy  output  1  high while a clear sweep runs

## Operation
- FSM states: IDLE and CLEAR.
- Reset: reset_n low at a rising edge gives:
  - state = CLEAR, sweep index = 0
  - every rs_out = 0, busy = 1
  - storage contents are not reset directly.
- CLEAR, each cycle:
  - write 0 to register[index], then increment index.
  - When index = NREGS−1 is written, next state = IDLE and busy = 0 from the following cycle.
  - A sweep takes exactly NREGS cycles.
- In CLEAR:
  - we is ignored.
  - clear is ignored; the sweep does not restart.
  - every rs_out loads 0.
- IDLE, writes: if we=1 and not (ZERO_REG=1 and rd=0), then register[rd] ← rd_in.
- IDLE, clear=1: next state = CLEAR, index = 0. Any write in the same cycle is dropped.
- IDLE, reads: for each port p, rs_out[p] ← next value, chosen by priority:
  1. 0 if ZERO_REG=1 and rs[p]=0
  2. rd_in if we=1 and rd=rs[p] (write-first bypass)
  3. register[rs[p]] otherwise
- Multiple ports may read the same address in one cycle; all return identical data.
- Widths: addresses are exactly log2(NREGS) bits, so no out-of-range addresses exist. Data is passed unmodified.
- reset_n low takes precedence over every other input in the same cycle, including mid-sweep (the sweep restarts at index 0).

## Timing
- Read latency: 1 cycle. rs[p] presented at edge N is visible on rs_out[p] after edge N+1.
- Write visible to a read:
  - in the same cycle, via the bypass;
  - in any later cycle, via storage.
- Clear (reset or pulse) to first accepted write: busy is low in the cycle after NREGS sweep cycles. A write presented in that cycle is accepted.
- busy is a registered output. rs_out holds its value between edges.

## Structure
- Package regfile_pkg holds:
  - state enum regfile_state_t {IDLE, CLEAR}
  - helper function addr_width(NREGS) = $clog2(NREGS)
- Sub-module regfile_read_port, instantiated NREAD times via generate. It contains:
  - the zero/bypass/storage mux
  - the rs_out flop
- The top level owns the storage array, sweep counter and FSM.

## Test plan
- Reset sweep:
  - Stimulus: hold reset_n low 1 cycle, then high; defaults.
  - Required: busy=1 for exactly 32 cycles, then 0. Every rs_out = 0 during the sweep. Afterwards all 32 registers read 0.
- Write/read:
  - Stimulus: write 0xDEADBEEF to r5; next cycle rs[0]=5, rs[1]=5.
  - Required: both rs_out = 0xDEADBEEF one cycle later.
- Bypass:
  - Stimulus: in the same cycle, we=1, rd=7, rd_in=0x12345678, rs[1]=7; r7 previously 0xAAAA0000.
  - Required: rs_out[1] = 0x12345678 after that edge.
- Zero register:
  - Stimulus: write 0xFFFFFFFF to r0, with rs[0]=0 in the same cycle and in the next cycle.
  - Required: rs_out[0] = 0 both times.
  - Repeat with ZERO_REG=0: required rs_out[0] = 0xFFFFFFFF, first via the bypass, then from storage.
- Clear pulse mid-operation:
  - Stimulus: fill r1–r31 with their own index; pulse clear; attempt a write to r3 during busy.
  - Required: write ignored, busy high for 32 cycles, then r3 reads 0.
  - Then assert reset_n low at sweep cycle 10. Required: busy continues and the sweep restarts, ending 32 cycles after the reset edge.
- Parameter sweep:
  - Stimulus: NREGS=8, NREAD=4, XLEN=16; write distinct values to r1–r7.
  - Required: all four ports read arbitrary, including duplicate, addresses correctly.
  - Required: clear sweep lasts 8 cycles.
